// File: rtl/vdp_seq_pkg.sv
// Shared opcodes, FSM states and byte-formatting helper for the VDP host sequencer.
package vdp_seq_pkg;

  localparam logic [2:0] OP_NOP         = 3'd0;
  localparam logic [2:0] OP_SET_REG     = 3'd1;
  localparam logic [2:0] OP_SET_WADDR   = 3'd2;
  localparam logic [2:0] OP_SET_RADDR   = 3'd3;
  localparam logic [2:0] OP_FILL        = 3'd4;
  localparam logic [2:0] OP_READ_DATA   = 3'd5;
  localparam logic [2:0] OP_READ_STATUS = 3'd6;
  localparam logic [2:0] OP_RSVD        = 3'd7;

  localparam logic [7:0] REG_WRITE_MARK = 8'h80;
  localparam logic [1:0] WADDR_PREFIX   = 2'b01;
  localparam logic [1:0] RADDR_PREFIX   = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WSTROBE,
    S_RSTROBE,
    S_GAP
  } seq_state_e;

  typedef struct packed {
    logic       mode;
    logic       is_read;
    logic [7:0] data;
  } bus_byte_t;

  // Bus setting for one byte slot; `second` selects the control byte of a two-byte command.
  function automatic bus_byte_t setup_byte(input logic [2:0]  op,
                                           input logic [13:0] arg,
                                           input logic [7:0]  data,
                                           input logic        second);
    bus_byte_t b;
    b.mode    = 1'b1;
    b.is_read = 1'b0;
    b.data    = data;
    case (op)
      OP_SET_REG:     b.data = second ? (REG_WRITE_MARK | {5'd0, arg[2:0]}) : data;
      OP_SET_WADDR:   b.data = second ? {WADDR_PREFIX, arg[13:8]} : arg[7:0];
      OP_SET_RADDR:   b.data = second ? {RADDR_PREFIX, arg[13:8]} : arg[7:0];
      OP_FILL:        b.mode = 1'b0;
      OP_READ_DATA: begin
        b.mode    = 1'b0;
        b.is_read = 1'b1;
      end
      OP_READ_STATUS: b.is_read = 1'b1;
      default:        ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vdp_strobe_timer.sv
// Loadable down-counter timing the strobe and gap phases; done while the count is zero.
module vdp_strobe_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vdp_host_sequencer.sv
// Turns valid/ready host commands into timed mode/data/wr/rd sequences on the TMS9918 CPU port.
module vdp_host_sequencer
  import vdp_seq_pkg::*;
#(
  parameter int WR_HOLD = 1,
  parameter int RD_HOLD = 4,
  parameter int GAP     = 2,
  parameter int CNT_W   = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [13:0]      cmd_arg,
  input  logic [7:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic             vdp_mode,
  output logic [7:0]       vdp_addr,
  output logic [7:0]       vdp_dout,
  input  logic [15:0]      vdp_din,
  output logic             vdp_wr,
  output logic             vdp_rd
);

  localparam int TMR_W = 8;

  seq_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [13:0]      arg_q, arg_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic [7:0]       dout_q, dout_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic             accept;
  bus_byte_t        bb;
  logic             unused_din;

  assign accept     = cmd_valid && cmd_ready;
  assign unused_din = ^vdp_din[7:0];

  vdp_strobe_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    data_d      = data_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    dout_d      = dout_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    bb          = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          arg_d  = cmd_arg;
          data_d = cmd_data;
          case (cmd_op)
            OP_SET_REG, OP_SET_WADDR, OP_SET_RADDR: rem_d = CNT_W'(2);
            OP_FILL:                                rem_d = cmd_count;
            OP_READ_DATA, OP_READ_STATUS:           rem_d = CNT_W'(1);
            default:                                rem_d = '0;
          endcase
          if (rem_d != '0) begin
            state_d = S_SETUP;
            bb      = setup_byte(cmd_op, cmd_arg, cmd_data, 1'b0);
            mode_d  = bb.mode;
            if (!bb.is_read) dout_d = bb.data;
          end else begin
            // Strobe-less commands still occupy a setup slot plus the gap.
            state_d  = S_GAP;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(GAP);
          end
        end
      end
      S_SETUP: begin
        bb       = setup_byte(op_q, arg_q, data_q, 1'b0);
        rem_d    = rem_q - CNT_W'(1);
        tmr_load = 1'b1;
        if (bb.is_read) begin
          state_d = S_RSTROBE;
          rd_d    = 1'b1;
          tmr_val = TMR_W'(RD_HOLD - 1);
        end else begin
          state_d = S_WSTROBE;
          wr_d    = 1'b1;
          tmr_val = TMR_W'(WR_HOLD - 1);
        end
      end
      S_WSTROBE: begin
        if (tmr_done) begin
          state_d  = S_GAP;
          wr_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP - 1);
        end
      end
      S_RSTROBE: begin
        if (tmr_done) begin
          state_d     = S_GAP;
          rd_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = vdp_din[15:8];
          tmr_load    = 1'b1;
          tmr_val     = TMR_W'(GAP - 1);
        end
      end
      S_GAP: begin
        if (tmr_done) begin
          if (rem_q != '0) begin
            state_d = S_SETUP;
            bb      = setup_byte(op_q, arg_q, data_q, rem_q == CNT_W'(1));
            mode_d  = bb.mode;
            if (!bb.is_read) dout_d = bb.data;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      arg_q       <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      mode_q      <= 1'b0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign vdp_mode  = mode_q;
  assign vdp_addr  = 8'h00;
  assign vdp_dout  = dout_q;
  assign vdp_wr    = wr_q;
  assign vdp_rd    = rd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vdp_host_sequencer.sv
// Bench for vdp_host_sequencer: vector table plus scoreboarded bus strobes against a small VDP port model.
module tb_vdp_host_sequencer;
  import vdp_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_valid2;
  logic [2:0]  cmd_op;
  logic [13:0] cmd_arg;
  logic [7:0]  cmd_data;
  logic [13:0] cmd_count;

  logic        cmd_ready, rsp_valid, busy, vdp_mode, vdp_wr, vdp_rd;
  logic [7:0]  rsp_data, vdp_addr, vdp_dout;
  logic [15:0] vdp_din;

  logic        cmd_ready2, rsp_valid2, busy2, vdp_mode2, vdp_wr2, vdp_rd2;
  logic [7:0]  rsp_data2, vdp_addr2, vdp_dout2;

  always #5 clk = ~clk;

  vdp_host_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .vdp_mode(vdp_mode),
    .vdp_addr(vdp_addr), .vdp_dout(vdp_dout), .vdp_din(vdp_din), .vdp_wr(vdp_wr), .vdp_rd(vdp_rd)
  );

  vdp_host_sequencer #(.WR_HOLD(3), .GAP(1)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .busy(busy2), .vdp_mode(vdp_mode2),
    .vdp_addr(vdp_addr2), .vdp_dout(vdp_dout2), .vdp_din(16'h0000), .vdp_wr(vdp_wr2), .vdp_rd(vdp_rd2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard entries: one per expected strobe, one per expected read result.
  typedef struct packed {
    logic       rd;
    logic       mode;
    logic [7:0] data;
  } bus_t;
  bus_t       bus_q[$];
  logic [7:0] rsp_q[$];

  // Minimal TMS9918 CPU-port model.
  logic [7:0]  vram [int];
  logic [13:0] vaddr = '0;
  logic [7:0]  first = '0;
  logic        phase = 1'b0;
  logic [7:0]  reg1 = '0;
  logic        int_flag = 1'b0;
  logic [7:0]  vram_out = '0;
  int          frame_req = 0;
  int          frame_seen = 0;

  assign vdp_din = vdp_mode ? {int_flag, 7'h00, 8'h00} : {vram_out, 8'h00};

  int   wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0, wr_w = 0, rd_w = 0;
  logic wr_prev = 1'b0, rd_prev = 1'b0, prev_mode = 1'b0;
  logic [7:0] prev_dout = '0;

  always @(negedge clk) begin
    bus_t e;
    if (frame_req != frame_seen) begin
      frame_seen = frame_req;
      if (reg1[5]) int_flag = 1'b1;
    end
    if (reset) begin
      bus_q.delete();
      rsp_q.delete();
      phase   = 1'b0;
      wr_prev = 1'b0;
      rd_prev = 1'b0;
      wr_w    = 0;
      rd_w    = 0;
    end else begin
      if (vdp_wr || vdp_rd) begin
        check("strobe_mode_stable", vdp_mode, prev_mode);
        check("strobe_dout_stable", vdp_dout, prev_dout);
      end
      if (vdp_wr && !wr_prev) begin
        wr_cnt++;
        check("wr_pending", bus_q.size() > 0, 1);
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          check("wr_kind", e.rd, 1'b0);
          check("wr_mode", vdp_mode, e.mode);
          check("wr_data", vdp_dout, e.data);
        end
        if (vdp_mode) begin
          if (!phase) begin
            first = vdp_dout;
            phase = 1'b1;
          end else begin
            phase = 1'b0;
            if (vdp_dout[7]) begin
              if (vdp_dout[2:0] == 3'd1) reg1 = first;
            end else begin
              vaddr = {vdp_dout[5:0], first};
            end
          end
        end else begin
          vram[int'(vaddr)] = vdp_dout;
          vaddr = vaddr + 14'd1;
        end
      end
      if (vdp_rd && !rd_prev) begin
        rd_cnt++;
        check("rd_pending", bus_q.size() > 0, 1);
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          check("rd_kind", e.rd, 1'b1);
          check("rd_mode", vdp_mode, e.mode);
        end
      end
      if (!vdp_wr && wr_prev) check("wr_width", wr_w, 1);
      if (!vdp_rd && rd_prev) begin
        check("rd_width", rd_w, 4);
        if (prev_mode) int_flag = 1'b0;
        else           vaddr = vaddr + 14'd1;
        phase = 1'b0;
      end
      wr_w = vdp_wr ? wr_w + 1 : 0;
      rd_w = vdp_rd ? rd_w + 1 : 0;
      if (rsp_valid) begin
        rsp_cnt++;
        check("rsp_pending", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) check("rsp_data", rsp_data, rsp_q.pop_front());
      end
      wr_prev = vdp_wr;
      rd_prev = vdp_rd;
    end
    if (reset) int_flag = 1'b0;
    prev_mode = vdp_mode;
    prev_dout = vdp_dout;
    vram_out  = vram.exists(int'(vaddr)) ? vram[int'(vaddr)] : 8'h00;
  end

  typedef struct {
    logic [2:0]  op;
    logic [13:0] arg;
    logic [7:0]  data;
    logic [13:0] count;
    bit          frame;
    int          cycles;
    int          nwr;
    int          nrd;
    logic        mode;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  rsp;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic start(input logic [2:0] op, input logic [13:0] arg,
                       input logic [7:0] data, input logic [13:0] count);
    int t;
    @(negedge clk);
    cmd_op = op; cmd_arg = arg; cmd_data = data; cmd_count = count;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_arg   = 14'($urandom);
    cmd_data  = 8'($urandom);
    cmd_count = 14'($urandom);
  endtask

  task automatic issue(input logic [2:0] op, input logic [13:0] arg,
                       input logic [7:0] data, input logic [13:0] count, output int cyc);
    start(op, arg, data, count);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  int          r2_n, r2_busy;
  int          r2_rise [3];
  logic [7:0]  r2_dout [3];

  task automatic run2(input logic [2:0] op, input logic [13:0] arg,
                      input logic [7:0] data, input logic [13:0] count);
    int   t, w;
    logic pw, pm;
    logic [7:0] pd;
    @(negedge clk);
    cmd_op = op; cmd_arg = arg; cmd_data = data; cmd_count = count;
    cmd_valid2 = 1'b1;
    t = 0;
    while (!cmd_ready2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept2_wait", cmd_ready2, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid2 = 1'b0;
    r2_n = 0; r2_busy = 0; w = 0; pw = 1'b0; pm = vdp_mode2; pd = vdp_dout2;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy2) r2_busy++;
      if (vdp_wr2) begin
        check("wr2_mode_stable", vdp_mode2, pm);
        check("wr2_dout_stable", vdp_dout2, pd);
      end
      if (vdp_wr2 && !pw) begin
        if (r2_n < 3) begin
          r2_rise[r2_n] = c;
          r2_dout[r2_n] = vdp_dout2;
        end
        r2_n++;
      end
      if (!vdp_wr2 && pw) check("wr2_width", w, 3);
      w  = vdp_wr2 ? w + 1 : 0;
      pw = vdp_wr2;
      pm = vdp_mode2;
      pd = vdp_dout2;
    end
    check("ready2_after", cmd_ready2, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, w0, r0, p0, t;
    vec_t v;

    vecs[0]  = '{OP_SET_REG,     14'h0001, 8'hEA, 14'd0, 1'b0, 8, 2, 0, 1'b1, 8'hEA, 8'h81, 8'h00};
    vecs[1]  = '{OP_SET_WADDR,   14'h1234, 8'h00, 14'd0, 1'b0, 8, 2, 0, 1'b1, 8'h34, 8'h52, 8'h00};
    vecs[2]  = '{OP_FILL,        14'h0000, 8'h5A, 14'd2, 1'b0, 8, 2, 0, 1'b0, 8'h5A, 8'h5A, 8'h00};
    vecs[3]  = '{OP_SET_RADDR,   14'h1234, 8'h00, 14'd0, 1'b0, 8, 2, 0, 1'b1, 8'h34, 8'h12, 8'h00};
    vecs[4]  = '{OP_READ_DATA,   14'h0000, 8'h00, 14'd0, 1'b0, 7, 0, 1, 1'b0, 8'h00, 8'h00, 8'h5A};
    vecs[5]  = '{OP_READ_DATA,   14'h0000, 8'h00, 14'd0, 1'b0, 7, 0, 1, 1'b0, 8'h00, 8'h00, 8'h5A};
    vecs[6]  = '{OP_READ_DATA,   14'h0000, 8'h00, 14'd0, 1'b0, 7, 0, 1, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[7]  = '{OP_NOP,         14'h0000, 8'h00, 14'd0, 1'b0, 3, 0, 0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[8]  = '{OP_RSVD,        14'h3FFF, 8'hFF, 14'd9, 1'b0, 3, 0, 0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[9]  = '{OP_FILL,        14'h0000, 8'h77, 14'd0, 1'b0, 3, 0, 0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[10] = '{OP_SET_REG,     14'h0007, 8'hF1, 14'd0, 1'b0, 8, 2, 0, 1'b1, 8'hF1, 8'h87, 8'h00};
    vecs[11] = '{OP_SET_WADDR,   14'h3FFF, 8'h00, 14'd0, 1'b0, 8, 2, 0, 1'b1, 8'hFF, 8'h7F, 8'h00};
    vecs[12] = '{OP_FILL,        14'h0000, 8'hA5, 14'd1, 1'b0, 4, 1, 0, 1'b0, 8'hA5, 8'hA5, 8'h00};
    vecs[13] = '{OP_SET_RADDR,   14'h3FFF, 8'h00, 14'd0, 1'b0, 8, 2, 0, 1'b1, 8'hFF, 8'h3F, 8'h00};
    vecs[14] = '{OP_READ_DATA,   14'h0000, 8'h00, 14'd0, 1'b0, 7, 0, 1, 1'b0, 8'h00, 8'h00, 8'hA5};
    vecs[15] = '{OP_READ_STATUS, 14'h0000, 8'h00, 14'd0, 1'b1, 7, 0, 1, 1'b1, 8'h00, 8'h00, 8'h80};
    vecs[16] = '{OP_READ_STATUS, 14'h0000, 8'h00, 14'd0, 1'b0, 7, 0, 1, 1'b1, 8'h00, 8'h00, 8'h00};
    vecs[17] = '{OP_FILL,        14'h0000, 8'hC3, 14'd5, 1'b0, 20, 5, 0, 1'b0, 8'hC3, 8'hC3, 8'h00};

    reset = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_op = '0; cmd_arg = '0; cmd_data = '0; cmd_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr", vdp_wr, 1'b0);
    check("rst_rd", vdp_rd, 1'b0);
    check("rst_mode", vdp_mode, 1'b0);
    check("rst_dout", vdp_dout, 8'h00);
    check("rst_addr", vdp_addr, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    reset = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      if (v.frame) frame_req++;
      for (int j = 0; j < v.nwr; j++) bus_q.push_back('{1'b0, v.mode, (j == 0) ? v.b0 : v.b1});
      for (int j = 0; j < v.nrd; j++) begin
        bus_q.push_back('{1'b1, v.mode, 8'h00});
        rsp_q.push_back(v.rsp);
      end
      w0 = wr_cnt; r0 = rd_cnt; p0 = rsp_cnt;
      issue(v.op, v.arg, v.data, v.count, cyc);
      check($sformatf("v%0d_busy_cycles", i), cyc, v.cycles);
      check($sformatf("v%0d_ready", i), cmd_ready, 1'b1);
      check($sformatf("v%0d_wr_count", i), wr_cnt - w0, v.nwr);
      check($sformatf("v%0d_rd_count", i), rd_cnt - r0, v.nrd);
      check($sformatf("v%0d_rsp_count", i), rsp_cnt - p0, v.nrd);
      check($sformatf("v%0d_bus_left", i), bus_q.size(), 0);
    end
    check("rsp_hold", rsp_data, 8'h00);

    // Reset in the middle of a long fill.
    for (int j = 0; j < 40; j++) bus_q.push_back('{1'b0, 1'b0, 8'h33});
    w0 = wr_cnt;
    start(OP_FILL, 14'h0000, 8'h33, 14'd40);
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (wr_cnt - w0 < 3 && t < 200);
    check("abort_third_strobe", wr_cnt - w0, 3);
    check("abort_wr_high", vdp_wr, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_wr", vdp_wr, 1'b0);
    check("abort_rd", vdp_rd, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_mode", vdp_mode, 1'b0);
    check("abort_dout", vdp_dout, 8'h00);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_ready_low", cmd_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready_after", cmd_ready, 1'b1);
    w0 = wr_cnt;
    repeat (10) @(negedge clk);
    check("abort_no_more_wr", wr_cnt - w0, 0);

    // Stretched strobe, short gap.
    run2(OP_SET_REG, 14'h0002, 8'h11, 14'd0);
    check("d2_set_strobes", r2_n, 2);
    check("d2_set_busy", r2_busy, 10);
    check("d2_set_first_rise", r2_rise[0], 2);
    check("d2_set_period", r2_rise[1] - r2_rise[0], 5);
    check("d2_set_b0", r2_dout[0], 8'h11);
    check("d2_set_b1", r2_dout[1], 8'h82);
    run2(OP_FILL, 14'h0000, 8'h5A, 14'd3);
    check("d2_fill_strobes", r2_n, 3);
    check("d2_fill_busy", r2_busy, 15);
    check("d2_fill_period0", r2_rise[1] - r2_rise[0], 5);
    check("d2_fill_period1", r2_rise[2] - r2_rise[1], 5);
    check("d2_fill_data", r2_dout[2], 8'h5A);
    check("d2_fill_mode_held", vdp_mode2, 1'b0);
    check("d2_fill_dout_held", vdp_dout2, 8'h5A);
    run2(OP_FILL, 14'h0000, 8'hEE, 14'd0);
    check("d2_fill0_strobes", r2_n, 0);
    check("d2_fill0_busy", r2_busy, 2);
    check("d2_fill0_dout_held", vdp_dout2, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vdp_host_sequencer.md
# vdp_host_sequencer

Synthesizable command sequencer that drives the CPU-side port of `tms9918` (mode, addr, data_in, wr, rd) from a simple valid/ready command stream. It turns the host operations the VDP needs into correctly timed strobe sequences: register set, VRAM write/read address setup, N-byte data fills, data reads and status reads. It sits between a host engine (boot ROM loader, soft CPU glue or test driver) and the VDP, replacing hand-written bus sequences.

## Interface
Parameters:
- `WR_HOLD`, default 1: cycles `vdp_wr` is held high per write strobe (≥1).
- `RD_HOLD`, default 4: cycles `vdp_rd` is held high per read strobe (≥1).
- `GAP`, default 2: idle cycles after every strobe, with bus outputs held (≥1).
- `CNT_W`, default 14: width of the fill repeat count.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer idle and able to accept.
- `cmd_op`  in  3  opcode (see Operation).
- `cmd_arg`  in  14  VRAM address or register number in [2:0].
- `cmd_data`  in  8  register value or fill byte.
- `cmd_count`  in  CNT_W  fill byte count.
- `rsp_valid`  out  1  one-cycle pulse, read result available.
- `rsp_data`  out  8  read result; holds until next read.
- `busy`  out  1  high from acceptance until return to IDLE.
- `vdp_mode`  out  1  to VDP `mode` (1 = register/status, 0 = memory).
- `vdp_addr`  out  8  to VDP `addr`; constant 0.
- `vdp_dout`  out  8  to VDP `data_in`.
- `vdp_din`  in  16  from VDP `data_out`; byte in [15:8].
- `vdp_wr`  out  1  write strobe.
- `vdp_rd`  out  1  read strobe.

## Operation
- Opcodes: 0 NOP; 1 SET_REG (mode=1, bytes `cmd_data`, `8'h80|arg[2:0]`); 2 SET_WADDR (mode=1, bytes `arg[7:0]`, `{2'b01,arg[13:8]}`); 3 SET_RADDR (mode=1, bytes `arg[7:0]`, `{2'b00,arg[13:8]}`); 4 FILL (mode=0, `cmd_data` written `cmd_count` times); 5 READ_DATA (mode=0, one read); 6 READ_STATUS (mode=1, one read); 7 reserved, executes as NOP.
- Command fields are latched at acceptance (`cmd_valid && cmd_ready`); inputs are don't-care afterwards.
- FSM: IDLE → SETUP → WSTROBE|RSTROBE → GAP → (SETUP for next byte | IDLE). NOP, reserved and FILL with count 0 go IDLE → GAP → IDLE and produce no strobes.
- `vdp_mode` and `vdp_dout` change only in SETUP, never while `vdp_wr`/`vdp_rd` is high; they hold their values through GAP and IDLE.
- Reads sample `vdp_din[15:8]` on the edge ending the last RSTROBE cycle; `rsp_valid` pulses in the first GAP cycle.
- Reset values: `cmd_ready`=0 during reset, 1 in the first cycle after; all other outputs 0. A reset mid-operation aborts the operation. Strobes are low from the next edge, and no `rsp_valid` is produced.

## Timing
- Accept at edge k. SETUP occupies cycle k+1. The strobe is high for the next WR_HOLD (or RD_HOLD) cycles, followed by GAP cycles.
- One byte costs 1+WR_HOLD+GAP cycles (4 at defaults). A read costs 1+RD_HOLD+GAP cycles (7 at defaults).
- SET_* = 2 bytes = 8 cycles at defaults. FILL of N bytes = 4N cycles.
- `cmd_ready` is low throughout. It rises in the cycle after the last GAP cycle, so back-to-back commands incur one IDLE cycle.
- FILL count is unsigned. The maximum is 2^CNT_W−1; the counter does not wrap.

## Structure
- Package `vdp_seq_pkg`: opcode localparams (`OP_NOP`…`OP_RSVD`), FSM state enum, register-write marker `8'h80`, address prefixes `2'b01`/`2'b00`.
- Sub-module `vdp_strobe_timer`: loadable down-counter shared by the strobe and gap phases, with a `done` output.

## Test plan
- After reset: SET_REG arg=1, data=EA → two mode=1 writes of `EA` then `81`, each with wr high 1 cycle; ready returns after 8 cycles.
- SET_WADDR 0x1234, FILL data=5A count=2, SET_RADDR 0x1234, READ_DATA against VDP model → `rsp_data`=5A, one `rsp_valid` pulse.
- READ_STATUS at ~17 ms with interrupt enabled → mode=1 during rd and `rsp_data[7]`=1; the second read returns bit7=0.
- FILL count=0 and op=7 → no wr/rd strobes, `busy` for 1+GAP cycles, then ready.
- Assert reset during the 3rd byte of FILL count=40 → wr low next cycle, all outputs 0, ready the cycle after reset drops.
- Check with WR_HOLD=3, GAP=1: strobe width 3 and byte period 5; mode/dout never change while wr=1.
